// File: rtl/fma_pkg.sv
// Shared types and width helpers for the FMA add/normalise datapath.
package fma_pkg;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rm_t;

  function automatic int aw(input int nf);
    return 3*nf + 6;
  endfunction

  function automatic int pw(input int nf);
    return 2*nf + 2;
  endfunction

  function automatic int xw(input int ne);
    return ne + 2;
  endfunction

endpackage

// File: rtl/fma_sum_core.sv
// Combinational adder core: forms both the direct sum and the negated-result sum
// so the stage after it only has to select the positive magnitude.
module fma_sum_core
  import fma_pkg::*;
#(
  parameter int NF = 10,
  localparam int AW = aw(NF),
  localparam int PW = pw(NF)
) (
  input  logic [AW-1:0] Am,
  input  logic [PW-1:0] Pm,
  input  logic          KillProd,
  input  logic          ASticky,
  input  logic          InvA,
  output logic [AW-1:0] PreSum,
  output logic [AW-1:0] NegPreSum,
  output logic          NegSum
);

  logic [AW-1:0] am_inv;
  logic [PW-1:0] pm_k;
  logic          cin;
  logic          neg_inc;
  logic [AW:0]   sum_full;

  assign am_inv  = InvA ? ~Am : Am;
  assign pm_k    = KillProd ? '0 : Pm;
  // The +1 completing the two's complement is withheld when sticky bits were lost.
  assign cin     = (~ASticky | KillProd) & InvA;
  assign neg_inc = ~ASticky | ~KillProd;

  assign sum_full  = {{(AW-PW-1){1'b0}}, pm_k, 2'b00}
                   + {InvA, am_inv}
                   + {{AW{1'b0}}, cin};
  assign NegPreSum = Am
                   + {{(AW-PW-2){1'b1}}, ~pm_k, 2'b00}
                   + {{(AW-3){1'b0}}, neg_inc, 2'b00};

  assign NegSum = sum_full[AW];
  assign PreSum = sum_full[AW-1:0];

endmodule

// File: rtl/fmaadd_pipe.sv
// Two-stage FMA add: S1 computes both candidate sums, S2 selects magnitude,
// sign, exponent and zero flag. Valid/ready elastic, 2-deep, synchronous flush.
module fmaadd_pipe
  import fma_pkg::*;
#(
  parameter int NF = 10,
  parameter int NE = 5,
  localparam int AW = aw(NF),
  localparam int PW = pw(NF),
  localparam int XW = xw(NE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] Am,
  input  logic [PW-1:0] Pm,
  input  logic [NE-1:0] Ze,
  input  logic [XW-1:0] Pe,
  input  logic          Ps,
  input  logic          KillProd,
  input  logic          ASticky,
  input  logic          InvA,
  input  logic [1:0]    Rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] Sm,
  output logic [XW-1:0] Se,
  output logic          Ss,
  output logic          SumZero
);

  logic [AW-1:0] pre_sum;
  logic [AW-1:0] neg_pre_sum;
  logic          neg_sum;

  logic          s1_valid;
  logic [AW-1:0] s1_pre_sum;
  logic [AW-1:0] s1_neg_pre_sum;
  logic          s1_neg_sum;
  logic [NE-1:0] s1_ze;
  logic [XW-1:0] s1_pe;
  logic          s1_ps;
  logic          s1_kill;
  logic          s1_inva;
  rm_t           s1_rm;

  logic          adv1;
  logic          take_in;
  logic [AW-1:0] sm_sel;
  logic          zero_sel;
  logic          sign_sel;

  fma_sum_core #(.NF(NF)) u_sum_core (
    .Am        (Am),
    .Pm        (Pm),
    .KillProd  (KillProd),
    .ASticky   (ASticky),
    .InvA      (InvA),
    .PreSum    (pre_sum),
    .NegPreSum (neg_pre_sum),
    .NegSum    (neg_sum)
  );

  assign adv1     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv1;
  assign take_in  = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_pre_sum     <= '0;
      s1_neg_pre_sum <= '0;
      s1_neg_sum     <= 1'b0;
      s1_ze          <= '0;
      s1_pe          <= '0;
      s1_ps          <= 1'b0;
      s1_kill        <= 1'b0;
      s1_inva        <= 1'b0;
      s1_rm          <= RZ;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (take_in) begin
        s1_pre_sum     <= pre_sum;
        s1_neg_pre_sum <= neg_pre_sum;
        s1_neg_sum     <= neg_sum;
        s1_ze          <= Ze;
        s1_pe          <= Pe;
        s1_ps          <= Ps;
        s1_kill        <= KillProd;
        s1_inva        <= InvA;
        s1_rm          <= rm_t'(Rm);
      end
    end
  end

  assign sm_sel   = s1_neg_sum ? s1_neg_pre_sum : s1_pre_sum;
  assign zero_sel = (sm_sel == '0);
  // An exact cancellation has no natural sign; it follows the rounding direction.
  assign sign_sel = (zero_sel & s1_inva & ~s1_kill) ? (s1_rm == RDN) : (s1_ps ^ s1_neg_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      Sm        <= '0;
      Se        <= '0;
      Ss        <= 1'b0;
      SumZero   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (adv1) begin
        out_valid <= s1_valid;
      end
      if (adv1 && s1_valid && !flush) begin
        Sm      <= sm_sel;
        Se      <= s1_kill ? {2'b00, s1_ze} : s1_pe;
        Ss      <= sign_sel;
        SumZero <= zero_sel;
      end
    end
  end

endmodule

// File: tb/tb_fmaadd_pipe.sv
// Bench for fmaadd_pipe: directed vector table, handshake corner sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_fmaadd_pipe;

  typedef struct {
    logic [35:0] am;
    logic [21:0] pm;
    logic [4:0]  ze;
    logic [6:0]  pe;
    logic        ps;
    logic        kill;
    logic        asticky;
    logic        inva;
    logic [1:0]  rm;
  } op_t;

  typedef struct {
    logic [35:0] sm;
    logic [6:0]  se;
    logic        ss;
    logic        zero;
  } res_t;

  typedef struct {
    op_t  op;
    res_t exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] Am;
  logic [21:0] Pm;
  logic [4:0]  Ze;
  logic [6:0]  Pe;
  logic        Ps;
  logic        KillProd;
  logic        ASticky;
  logic        InvA;
  logic [1:0]  Rm;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] Sm;
  logic [6:0]  Se;
  logic        Ss;
  logic        SumZero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_emit   = 0;
  res_t q[$];
  bit   prev_stall = 0;
  res_t held;
  bit   last_in_ready;

  fmaadd_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Am        (Am),
    .Pm        (Pm),
    .Ze        (Ze),
    .Pe        (Pe),
    .Ps        (Ps),
    .KillProd  (KillProd),
    .ASticky   (ASticky),
    .InvA      (InvA),
    .Rm        (Rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sm        (Sm),
    .Se        (Se),
    .Ss        (Ss),
    .SumZero   (SumZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [35:0] am, input logic [21:0] pm, input logic [4:0] ze,
                                input logic [6:0] pe, input logic ps, input logic kill,
                                input logic asticky, input logic inva, input logic [1:0] rm);
    op_t o;
    o.am = am; o.pm = pm; o.ze = ze; o.pe = pe; o.ps = ps;
    o.kill = kill; o.asticky = asticky; o.inva = inva; o.rm = rm;
    return o;
  endfunction

  // Signed arithmetic view: product*4 plus or minus the addend, with modular wrap.
  function automatic res_t model(input op_t o);
    res_t r;
    longint unsigned m36, m37, a, pk, s37, npre, sm;
    bit neg;
    m36 = 64'd1 << 36;
    m37 = 64'd1 << 37;
    a   = 64'(o.am);
    pk  = o.kill ? 64'd0 : 64'(o.pm);
    if (o.inva)
      s37 = (4*pk + (m37 - 1 - a) + ((!o.asticky || o.kill) ? 64'd1 : 64'd0)) % m37;
    else
      s37 = (4*pk + a) % m37;
    neg  = (s37 >= m36);
    npre = (a + m36 - 4*pk - 4 + ((!o.asticky || !o.kill) ? 64'd4 : 64'd0)) % m36;
    sm   = neg ? npre : (s37 % m36);
    r.sm   = sm[35:0];
    r.zero = (sm == 0);
    r.se   = o.kill ? {2'b00, o.ze} : o.pe;
    r.ss   = (r.zero && o.inva && !o.kill) ? (o.rm == 2'b10) : (o.ps ^ neg);
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.pm      = 22'($urandom);
    o.ze      = 5'($urandom);
    o.pe      = 7'($urandom);
    o.ps      = 1'($urandom);
    o.kill    = ($urandom_range(0, 7) == 0);
    o.asticky = 1'($urandom);
    o.inva    = 1'($urandom);
    o.rm      = 2'($urandom);
    case ($urandom_range(0, 3))
      0: o.am = {4'($urandom), 32'($urandom)};
      1: begin o.am = {12'b0, o.pm, 2'b00}; o.inva = 1'b1; o.kill = 1'b0; end
      2: o.am = {12'b0, o.pm, 2'b00} + 36'($urandom_range(0, 15)) - 36'd8;
      default: o.am = {12'b0, 24'($urandom)};
    endcase
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    Am = o.am; Pm = o.pm; Ze = o.ze; Pe = o.pe; Ps = o.ps;
    KillProd = o.kill; ASticky = o.asticky; InvA = o.inva; Rm = o.rm;
  endtask

  // One clock of traffic: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit iv, input op_t o, input bit ordy, input bit fl, output bit acc);
    res_t e;
    bit emit;
    in_valid = iv; drive_op(o); out_ready = ordy; flush = fl;
    #1;
    last_in_ready = in_ready;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sm", Sm, held.sm);
      chk("hold_se", Se, held.se);
      chk("hold_ss", {Ss, SumZero}, {held.ss, held.zero});
    end
    emit = out_valid && out_ready;
    acc  = iv && in_ready && !fl;
    if (emit) begin
      n_emit++;
      chk("spurious_output", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_sm", Sm, e.sm);
        chk("out_se", Se, e.se);
        chk("out_ss", Ss, e.ss);
        chk("out_zero", SumZero, e.zero);
      end
    end
    prev_stall = out_valid && !out_ready && !fl;
    held.sm = Sm; held.se = Se; held.ss = Ss; held.zero = SumZero;
    if (fl) q.delete();
    if (acc) q.push_back(model(o));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  op_t  bp_ops[4];

  initial begin
    bit a;
    int idx;
    int base;
    op_t idle_op;

    vecs[0] = '{mk_op(36'h0_0000_0000, 22'h100000, 5'd3, 7'd20, 0, 0, 0, 0, 2'b01),
                '{36'h0_0040_0000, 7'd20, 1'b0, 1'b0}};
    vecs[1] = '{mk_op(36'h0_1234_5678, 22'h3FFFFF, 5'd15, 7'd99, 1, 1, 0, 0, 2'b01),
                '{36'h0_1234_5678, 7'd15, 1'b1, 1'b0}};
    vecs[2] = '{mk_op(36'h0_0040_0000, 22'h100000, 5'd0, 7'd10, 0, 0, 0, 1, 2'b01),
                '{36'h0, 7'd10, 1'b0, 1'b1}};
    vecs[3] = '{mk_op(36'h0_0040_0000, 22'h100000, 5'd0, 7'd10, 0, 0, 0, 1, 2'b10),
                '{36'h0, 7'd10, 1'b1, 1'b1}};
    vecs[4] = '{mk_op(36'h0_0040_0000, 22'h100000, 5'd0, 7'd10, 0, 0, 0, 1, 2'b11),
                '{36'h0, 7'd10, 1'b0, 1'b1}};
    vecs[5] = '{mk_op(36'h0_0080_0000, 22'h100000, 5'd0, 7'd12, 0, 0, 0, 1, 2'b01),
                '{36'h0_0040_0000, 7'd12, 1'b1, 1'b0}};
    vecs[6] = '{mk_op(36'h0_0000_0000, 22'h2AAAAA, 5'd7, 7'd50, 1, 1, 0, 1, 2'b10),
                '{36'h0, 7'd7, 1'b1, 1'b1}};

    idle_op = mk_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_op(idle_op);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {Sm, Se, Ss, SumZero}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors: one op at a time, checking latency and result.
    foreach (vecs[i]) begin
      drive_op(vecs[i].op);
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat_early", i), out_valid, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_sm", i), Sm, vecs[i].exp.sm);
      chk($sformatf("v%0d_se", i), Se, vecs[i].exp.se);
      chk($sformatf("v%0d_ss", i), Ss, vecs[i].exp.ss);
      chk($sformatf("v%0d_zero", i), SumZero, vecs[i].exp.zero);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Backpressure: four ops offered while the sink is stalled for four cycles.
    foreach (bp_ops[i]) bp_ops[i] = rand_op();
    base = n_emit;
    idx  = 0;
    for (int t = 0; t < 16; t++) begin
      cycle(idx < 4, bp_ops[idx < 4 ? idx : 0], t >= 4, 0, a);
      if (t == 2) chk("bp_in_ready_low", last_in_ready, 0);
      if (a) idx++;
      if (t == 3) chk("bp_accepts_while_stalled", idx, 2);
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_all_emitted", n_emit - base, 4);
    chk("bp_queue_empty", q.size(), 0);

    // Flush with two ops in flight plus one offered in the flush cycle.
    cycle(1, rand_op(), 0, 0, a);
    cycle(1, rand_op(), 0, 0, a);
    cycle(1, rand_op(), 0, 1, a);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    base = n_emit;
    for (int t = 0; t < 5; t++) cycle(0, idle_op, 1, 0, a);
    chk("flush_no_output", n_emit - base, 0);

    // Asynchronous reset in the middle of a stalled stream.
    cycle(1, rand_op(), 0, 0, a);
    cycle(1, rand_op(), 0, 0, a);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_outputs", {Sm, Se, Ss, SumZero}, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    prev_stall = 0;
    @(posedge clk);
    #1;
    chk("arst_held_in_ready", in_ready, 1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_release_valid", out_valid, 0);

    // Randomized traffic with occasional flushes.
    for (int t = 0; t < 400; t++)
      cycle($urandom_range(0, 9) < 7, rand_op(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, a);
    for (int t = 0; t < 10; t++) cycle(0, idle_op, 1, 0, a);
    chk("final_queue_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmaadd_pipe.md
# fmaadd_pipe

Parametrised, pipelined successor to the fma16 combinational add stage. Adds the (possibly killed) product significand to the aligned, conditionally inverted addend, and selects the positive-magnitude sum, sign and exponent. Adds valid/ready flow control, a synchronous flush, an exact-zero flag and rounding-mode-correct zero sign. Sits between the alignment shifter and the normalisation/rounding stage of the FMA datapath.

## Interface
- NF, default 10: fraction bits; the default gives half precision.
- NE, default 5: exponent bits.
- Derived widths:
  - AW = 3*NF+6: aligned-addend and sum width (36).
  - PW = 2*NF+2: product significand width (22).
  - XW = NE+2: extended exponent width (7).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  stage can accept this cycle.
- Am  in  AW  aligned addend significand.
- Pm  in  PW  product significand.
- Ze  in  NE  addend exponent.
- Pe  in  XW  product exponent.
- Ps  in  1  product sign.
- KillProd  in  1  product negligible; result is the addend.
- ASticky  in  1  sticky bit shifted out of the addend.
- InvA  in  1  effective subtraction.
- Rm  in  2  rounding mode (00 RZ, 01 RNE, 10 RDN, 11 RUP).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts this cycle.
- Sm  out  AW  sum magnitude.
- Se  out  XW  sum exponent.
- Ss  out  1  sum sign.
- SumZero  out  1  Sm is exactly zero.

## Operation
- Stage S1 registers the following, computed from the inputs:
  - AmInv = InvA ? ~Am : Am.
  - PmK = KillProd ? 0 : Pm.
  - {NegSum, PreSum} (AW+1 bits) = zext(PmK)<<2 + {InvA, AmInv} + ((~ASticky|KillProd)&InvA).
  - NegPreSum (AW bits) = Am + {ones(AW-PW-2), ~PmK, 2'b00} + ((~ASticky|~KillProd)<<2).
  - Also registered: Ze, Pe, Ps, KillProd, InvA, Rm.
- Stage S2 registers the outputs:
  - Sm = NegSum ? NegPreSum : PreSum.
  - Se = KillProd ? zext(Ze) : Pe.
  - SumZero = (Sm == 0).
  - Ss = (SumZero & InvA & ~KillProd) ? (Rm == RDN) : Ps ^ NegSum.
- All additions are modulo their stated widths. Carry out of the AW+1-bit sum is discarded.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - in_ready = ~s1_valid | adv1, where adv1 = ~s2_valid | out_ready. in_ready is combinational from out_ready.
  - Outputs hold stable while out_valid & ~out_ready.
  - Order is preserved; no operation is dropped or duplicated except by flush or reset.
- flush: s1_valid and s2_valid are 0 next cycle. An input presented in the flush cycle is discarded.

## Timing
- Latency is 2 cycles: accepted at edge t, out_valid at t+2 when out_ready stays high.
- Throughput is 1 op/cycle at no stall. Capacity is 2 ops; in_ready falls only when both stages are full and out_ready=0.
- Reset values: out_valid=0, Sm=0, Se=0, Ss=0, SumZero=0, internal valids 0.
- in_ready=1 during and immediately after reset.
- Reset is asynchronous and may assert mid-operation; in-flight operations are lost.
- Simultaneous accept and emit in one cycle is legal, with stages full or not.

## Structure
- Package fma_pkg holds:
  - The rm_t enum (RZ, RNE, RDN, RUP).
  - Width functions aw(NF), pw(NF), xw(NE).
- Sub-module fma_sum_core is purely combinational: AmInv/PmK, PreSum/NegPreSum/NegSum. It is instantiated in S1.
- fmaadd_pipe contains the pipeline registers, select logic, zero/sign logic and handshake.

## Test plan
- Plain add:
  - Stimulus: InvA=0, KillProd=0, Am=0, Pm=22'h100000, Pe=7'd20, Ps=0.
  - Response 2 cycles later: Sm=36'h0_0040_0000, Se=20, Ss=0, SumZero=0.
- Killed product:
  - Stimulus: KillProd=1, InvA=0, Am=36'h0_1234_5678, Ze=15, Ps=1.
  - Response: Sm=36'h0_1234_5678, Se=7'd15, Ss=1.
- Exact cancellation:
  - Stimulus: InvA=1, ASticky=0, Am=36'h0_0040_0000, Pm=22'h100000, Ps=0.
  - Response with Rm=RNE: Sm=0, SumZero=1, Ss=0.
  - Response with Rm=RDN: Ss=1.
- Negative sum:
  - Stimulus: InvA=1, ASticky=0, Am=36'h0_0080_0000, Pm=22'h100000, Ps=0.
  - Response: Sm=36'h0_0040_0000, Ss=1.
- Backpressure:
  - Stimulus: 4 back-to-back ops with out_ready=0 for 4 cycles.
  - Required: in_ready falls after 2 accepts; outputs held stable; all 4 ops emerge in order once out_ready=1.
- Flush and reset:
  - Stimulus: flush with 2 ops in flight.
  - Required: out_valid=0 next cycle; neither op appears.
  - Stimulus: reset asserted asynchronously mid-stream.
  - Required: all outputs 0 immediately; in_ready=1.
